// File: rtl/layer_seq_pkg.sv
// Shared types and constants for the layer sequencer: FSM state encoding,
// default sizing and a stage-index width helper that tolerates a single stage.
package layer_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    ERROR  = 2'd3
  } seq_state_e;

  localparam int unsigned DEFAULT_STAGES  = 7;
  localparam int unsigned DEFAULT_TIMEOUT = 1024;

  // $clog2(1) is 0; a one-stage chain still needs a 1-bit index.
  function automatic int unsigned stage_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Per-stage cycle watchdog: counts enabled cycles since the last clear and
// flags expiry once TIMEOUT_CYCLES cycles have elapsed, holding at the limit.
module seq_watchdog
  import layer_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired_c
);

  localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign o_expired_c = (count_q == CNT_LAST);

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable && !o_expired_c) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// Runs the conv/relu stage chain as one job with per-stage watchdog, abort and
// sticky error. Define LAYER_SEQ_PERF_EN to add the o_last_job_cycles counter.
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES     = DEFAULT_STAGES,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int unsigned STAGE_W        = stage_width(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [NUM_STAGES-1:0] i_stage_done,
  output logic [NUM_STAGES-1:0] o_stage_start,
  output logic                  o_busy,
  output logic                  o_done_tick,
  output logic                  o_error,
  output logic [STAGE_W-1:0]    o_cur_stage
`ifdef LAYER_SEQ_PERF_EN
  ,
  output logic [31:0]           o_last_job_cycles
`endif
);

  seq_state_e              state_q, state_d;
  logic [NUM_STAGES-1:0]   stage_start_q, stage_start_d;
  logic                    busy_q, busy_d;
  logic                    done_tick_q, done_tick_d;
  logic                    error_q, error_d;
  logic [STAGE_W-1:0]      cur_stage_q, cur_stage_d;
  logic                    done_pend_q, done_pend_d;

  logic cur_done_c;
  logic last_stage_c;
  logic job_start_c;
  logic wd_clear_c;
  logic wd_enable_c;
  logic wd_expired_c;

  assign cur_done_c   = i_stage_done[cur_stage_q];
  assign last_stage_c = (cur_stage_q == STAGE_W'(NUM_STAGES - 1));

  seq_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (wd_clear_c),
    .i_enable    (wd_enable_c),
    .o_expired_c (wd_expired_c)
  );

  // A done seen in the LAUNCH cycle is held in done_pend so WAIT can act on it.
  always_comb begin
    state_d       = state_q;
    cur_stage_d   = cur_stage_q;
    error_d       = error_q;
    done_tick_d   = 1'b0;
    done_pend_d   = 1'b0;
    job_start_c   = 1'b0;
    wd_clear_c    = 1'b0;
    wd_enable_c   = 1'b0;

    case (state_q)
      IDLE, ERROR: begin
        if (i_start) begin
          state_d     = LAUNCH;
          cur_stage_d = '0;
          error_d     = 1'b0;
          job_start_c = 1'b1;
          wd_clear_c  = 1'b1;
        end
      end
      LAUNCH: begin
        wd_enable_c = 1'b1;
        if (i_abort) begin
          state_d = IDLE;
        end else begin
          state_d     = WAIT;
          done_pend_d = cur_done_c;
        end
      end
      WAIT: begin
        wd_enable_c = 1'b1;
        if (i_abort) begin
          state_d = IDLE;
        end else if (cur_done_c || done_pend_q) begin
          if (last_stage_c) begin
            state_d     = IDLE;
            done_tick_d = 1'b1;
          end else begin
            state_d     = LAUNCH;
            cur_stage_d = cur_stage_q + STAGE_W'(1);
            wd_clear_c  = 1'b1;
          end
        end else if (wd_expired_c) begin
          state_d = ERROR;
          error_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    stage_start_d = (state_d == LAUNCH) ? (NUM_STAGES'(1) << cur_stage_d) : '0;
    busy_d        = (state_d == LAUNCH) || (state_d == WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      stage_start_q <= '0;
      busy_q        <= 1'b0;
      done_tick_q   <= 1'b0;
      error_q       <= 1'b0;
      cur_stage_q   <= '0;
      done_pend_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      stage_start_q <= stage_start_d;
      busy_q        <= busy_d;
      done_tick_q   <= done_tick_d;
      error_q       <= error_d;
      cur_stage_q   <= cur_stage_d;
      done_pend_q   <= done_pend_d;
    end
  end

  assign o_stage_start = stage_start_q;
  assign o_busy        = busy_q;
  assign o_done_tick   = done_tick_q;
  assign o_error       = error_q;
  assign o_cur_stage   = cur_stage_q;

`ifdef LAYER_SEQ_PERF_EN
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [31:0] run_cnt_q, run_cnt_d;
  logic [31:0] last_cycles_q, last_cycles_d;
  logic [31:0] run_cnt_inc_c;

  // run_cnt is 0 in the first start-pulse cycle, so +1 at the last edge includes the tick cycle.
  always_comb begin
    run_cnt_inc_c = (run_cnt_q == CNT_MAX) ? CNT_MAX : run_cnt_q + 32'd1;
    run_cnt_d     = run_cnt_q;
    last_cycles_d = last_cycles_q;
    if (job_start_c) begin
      run_cnt_d = '0;
    end else if (busy_q) begin
      run_cnt_d = run_cnt_inc_c;
    end
    if (done_tick_d) begin
      last_cycles_d = run_cnt_inc_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_q     <= '0;
      last_cycles_q <= '0;
    end else begin
      run_cnt_q     <= run_cnt_d;
      last_cycles_q <= last_cycles_d;
    end
  end

  assign o_last_job_cycles = last_cycles_q;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer (4 stages, 16-cycle watchdog); expected
// start/done events are queued at stimulus time and matched against observed ones.
module tb_layer_sequencer;

  localparam int NS   = 4;
  localparam int TO   = 16;
  localparam int TICK = 15;
  localparam int BAD  = 99;

  typedef struct {
    int code;
    int cyc;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start;
  logic          i_abort;
  logic [NS-1:0] resp_done = '0;
  logic [NS-1:0] spur_done;
  wire  [NS-1:0] i_stage_done;
  logic [NS-1:0] o_stage_start;
  logic          o_busy;
  logic          o_done_tick;
  logic          o_error;
  logic [1:0]    o_cur_stage;
`ifdef LAYER_SEQ_PERF_EN
  logic [31:0]   o_last_job_cycles;
`endif

  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];

  int  resp_delay = 3;
  int  resp_block = -1;
  bit  r_pend     = 1'b0;
  int  r_cnt      = 0;
  int  r_stage    = 0;

  assign i_stage_done = resp_done | spur_done;

  layer_sequencer #(
    .NUM_STAGES     (NS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_stage_done  (i_stage_done),
    .o_stage_start (o_stage_start),
    .o_busy        (o_busy),
    .o_done_tick   (o_done_tick),
    .o_error       (o_error),
    .o_cur_stage   (o_cur_stage)
`ifdef LAYER_SEQ_PERF_EN
    ,
    .o_last_job_cycles (o_last_job_cycles)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stage model: answers each start pulse with a done tick resp_delay cycles later.
  always @(negedge clk) begin
    resp_done = '0;
    if (!rst_n) begin
      r_pend = 1'b0;
    end else begin
      if (r_pend) begin
        if (r_cnt == 0) begin
          resp_done[r_stage] = 1'b1;
          r_pend = 1'b0;
        end else begin
          r_cnt = r_cnt - 1;
        end
      end
      for (int k = 0; k < NS; k++) begin
        if (o_stage_start[k] && k != resp_block) begin
          if (resp_delay == 0) begin
            resp_done[k] = 1'b1;
          end else begin
            r_pend  = 1'b1;
            r_cnt   = resp_delay - 1;
            r_stage = k;
          end
        end
      end
    end
  end

  // Output monitor: every start pulse and done tick becomes an observed event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_stage_start != '0) begin
        if ($countones(o_stage_start) != 1) begin
          obs_q.push_back('{BAD, cyc});
        end else begin
          for (int k = 0; k < NS; k++) begin
            if (o_stage_start[k]) obs_q.push_back('{k, cyc});
          end
        end
      end
      if (o_done_tick) obs_q.push_back('{TICK, cyc});
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout bench did not finish");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns the cycle in which stage 0's start pulse is expected.
  task automatic pulse_start(output int s);
    @(negedge clk);
    i_start = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic push_job(input int s, input int per, input bit with_tick, input int nst);
    for (int k = 0; k < nst; k++) exp_q.push_back('{k, s + per * k});
    if (with_tick) exp_q.push_back('{TICK, s + per * NS});
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; spur_done = '0;
    idle(3);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (o_stage_start !== 4'b0000) begin failures++; $display("FAIL reset_start got %b want 0000", o_stage_start); end
    checks++; if (o_busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got %b want 0", o_busy); end
    checks++; if (o_done_tick !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", o_done_tick); end
    checks++; if (o_error !== 1'b0)     begin failures++; $display("FAIL reset_error got %b want 0", o_error); end
    checks++; if (o_cur_stage !== 2'd0) begin failures++; $display("FAIL reset_cur got %0d want 0", o_cur_stage); end
`ifdef LAYER_SEQ_PERF_EN
    checks++; if (o_last_job_cycles !== 32'd0) begin failures++; $display("FAIL reset_perf got %0d want 0", o_last_job_cycles); end
`endif
  endtask

  task automatic test_basic();
    int s;
    ev_t e, o;
    exp_q.delete(); obs_q.delete();
    resp_delay = 3; resp_block = -1;
    pulse_start(s);
    push_job(s, 4, 1'b1, NS);
    checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL basic_busy_hi got %b want 1", o_busy); end
    idle(25);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL basic_missing want ev %0d at %0d", e.code, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.code !== e.code || o.cyc !== e.cyc) begin failures++; $display("FAIL basic_ev got %0d@%0d want %0d@%0d", o.code, o.cyc, e.code, e.cyc); end
      end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL basic_extra got %0d extra events want 0", obs_q.size()); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL basic_busy_lo got %b want 0", o_busy); end
`ifdef LAYER_SEQ_PERF_EN
    checks++; if (o_last_job_cycles !== 32'd16) begin failures++; $display("FAIL basic_perf got %0d want 16", o_last_job_cycles); end
`endif
  endtask

  task automatic test_zero_latency();
    int s;
    ev_t e, o;
    exp_q.delete(); obs_q.delete();
    resp_delay = 0; resp_block = -1;
    pulse_start(s);
    push_job(s, 2, 1'b1, NS);
    idle(15);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL zlat_missing want ev %0d at %0d", e.code, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.code !== e.code || o.cyc !== e.cyc) begin failures++; $display("FAIL zlat_ev got %0d@%0d want %0d@%0d", o.code, o.cyc, e.code, e.cyc); end
      end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL zlat_extra got %0d extra events want 0", obs_q.size()); end
`ifdef LAYER_SEQ_PERF_EN
    checks++; if (o_last_job_cycles !== 32'd8) begin failures++; $display("FAIL zlat_perf got %0d want 8", o_last_job_cycles); end
`endif
  endtask

  task automatic test_timeout();
    int s;
    ev_t e, o;
    exp_q.delete(); obs_q.delete();
    resp_delay = 3; resp_block = 2;
    pulse_start(s);
    push_job(s, 4, 1'b0, 3);
    idle(23);
    checks++; if (o_error !== 1'b0) begin failures++; $display("FAIL tmo_early got %b want 0", o_error); end
    @(negedge clk);
    checks++; if (o_error !== 1'b1) begin failures++; $display("FAIL tmo_error got %b want 1", o_error); end
    checks++; if (o_cur_stage !== 2'd2) begin failures++; $display("FAIL tmo_stage got %0d want 2", o_cur_stage); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL tmo_busy got %b want 0", o_busy); end
    idle(6);
    checks++; if (o_error !== 1'b1) begin failures++; $display("FAIL tmo_sticky got %b want 1", o_error); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL tmo_missing want ev %0d at %0d", e.code, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.code !== e.code || o.cyc !== e.cyc) begin failures++; $display("FAIL tmo_ev got %0d@%0d want %0d@%0d", o.code, o.cyc, e.code, e.cyc); end
      end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL tmo_extra got %0d extra events want 0", obs_q.size()); end
    exp_q.delete(); obs_q.delete();
    resp_block = -1;
    pulse_start(s);
    push_job(s, 4, 1'b1, NS);
    checks++; if (o_error !== 1'b0) begin failures++; $display("FAIL tmo_clear got %b want 0", o_error); end
    checks++; if (o_stage_start !== 4'b0001) begin failures++; $display("FAIL tmo_restart got %b want 0001", o_stage_start); end
    idle(25);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL tmo2_missing want ev %0d at %0d", e.code, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.code !== e.code || o.cyc !== e.cyc) begin failures++; $display("FAIL tmo2_ev got %0d@%0d want %0d@%0d", o.code, o.cyc, e.code, e.cyc); end
      end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL tmo2_extra got %0d extra events want 0", obs_q.size()); end
  endtask

  task automatic test_abort();
    int s;
    ev_t e, o;
    exp_q.delete(); obs_q.delete();
    resp_delay = 3; resp_block = 1;
    pulse_start(s);
    push_job(s, 4, 1'b0, 2);
    idle(6);
    i_abort = 1'b1; spur_done = 4'b0010;
    @(negedge clk);
    i_abort = 1'b0; spur_done = '0;
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL abort_busy got %b want 0", o_busy); end
    idle(20);
    checks++; if (o_error !== 1'b0) begin failures++; $display("FAIL abort_error got %b want 0", o_error); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL abort_missing want ev %0d at %0d", e.code, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.code !== e.code || o.cyc !== e.cyc) begin failures++; $display("FAIL abort_ev got %0d@%0d want %0d@%0d", o.code, o.cyc, e.code, e.cyc); end
      end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL abort_extra got %0d extra events want 0", obs_q.size()); end
    resp_block = -1;
  endtask

  task automatic test_spurious();
    int s;
    ev_t e, o;
    exp_q.delete(); obs_q.delete();
    resp_delay = 3; resp_block = -1;
    pulse_start(s);
    push_job(s, 4, 1'b1, NS);
    i_start = 1'b1; spur_done = 4'b1000;
    @(negedge clk);
    i_start = 1'b0; spur_done = '0;
    idle(4);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    idle(20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL spur_missing want ev %0d at %0d", e.code, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.code !== e.code || o.cyc !== e.cyc) begin failures++; $display("FAIL spur_ev got %0d@%0d want %0d@%0d", o.code, o.cyc, e.code, e.cyc); end
      end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL spur_extra got %0d extra events want 0", obs_q.size()); end
    checks++; if (o_error !== 1'b0) begin failures++; $display("FAIL spur_error got %b want 0", o_error); end
  endtask

  task automatic test_reset_mid_job();
    int s;
    ev_t e, o;
    exp_q.delete(); obs_q.delete();
    resp_delay = 3; resp_block = -1;
    pulse_start(s);
    push_job(s, 4, 1'b0, 2);
    idle(5);
    rst_n = 1'b0;
    #1;
    checks++; if (o_busy !== 1'b0)      begin failures++; $display("FAIL rstmid_busy got %b want 0", o_busy); end
    checks++; if (o_cur_stage !== 2'd0) begin failures++; $display("FAIL rstmid_cur got %0d want 0", o_cur_stage); end
    checks++; if (o_stage_start !== 4'b0000 || o_done_tick !== 1'b0 || o_error !== 1'b0) begin
      failures++; $display("FAIL rstmid_out got start=%b done=%b err=%b want 0000/0/0", o_stage_start, o_done_tick, o_error);
    end
`ifdef LAYER_SEQ_PERF_EN
    checks++; if (o_last_job_cycles !== 32'd0) begin failures++; $display("FAIL rstmid_perf got %0d want 0", o_last_job_cycles); end
`endif
    idle(3);
    rst_n = 1'b1;
    idle(20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL rstmid_missing want ev %0d at %0d", e.code, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.code !== e.code || o.cyc !== e.cyc) begin failures++; $display("FAIL rstmid_ev got %0d@%0d want %0d@%0d", o.code, o.cyc, e.code, e.cyc); end
      end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL rstmid_extra got %0d extra events want 0", obs_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_latency();
    test_timeout();
    test_abort();
    test_spurious();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
